// File: rtl/prog_imem_if.sv
// Fetch and load-port bundle for prog_imem: the pipeline/loader side is the
// master, the instruction memory is the slave.
interface prog_imem_if #(
    parameter int INSTR_W = 9,
    parameter int ADDR_W  = 8,
    parameter int BANK_W  = 2
);
    logic [ADDR_W-1:0]  pc;
    logic [BANK_W-1:0]  bank_sel;
    logic               fetch_en;
    logic               flush;
    logic [INSTR_W-1:0] instr_out;
    logic               instr_valid;
    logic               load_start;
    logic [BANK_W-1:0]  load_bank;
    logic [INSTR_W-1:0] load_data;
    logic               load_valid;
    logic               load_last;
    logic               load_ready;
    logic               busy;
    logic               load_done;
    logic               load_err;

    modport master (
        output pc, bank_sel, fetch_en, flush,
        output load_start, load_bank, load_data, load_valid, load_last,
        input  instr_out, instr_valid, load_ready, busy, load_done, load_err
    );

    modport slave (
        input  pc, bank_sel, fetch_en, flush,
        input  load_start, load_bank, load_data, load_valid, load_last,
        output instr_out, instr_valid, load_ready, busy, load_done, load_err
    );
endinterface

// File: rtl/prog_imem.sv
// Banked, run-time loadable instruction memory with registered fetch (stall/flush).
// Optional even-parity protection of stored words is enabled by IMEM_PARITY_EN.
module prog_imem #(
    parameter int                 INSTR_W   = 9,
    parameter int                 ADDR_W    = 8,
    parameter int                 NUM_BANKS = 4,
    parameter logic [INSTR_W-1:0] NOP_WORD  = 9'b110111000
) (
    input  logic       clk,
    input  logic       reset,
    prog_imem_if.slave bus
`ifdef IMEM_PARITY_EN
    ,
    output logic       parity_err
`endif
);
    localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int MEM_WORDS = 2 ** (BANK_W + ADDR_W);
`ifdef IMEM_PARITY_EN
    localparam int MEM_W     = INSTR_W + 1;
`else
    localparam int MEM_W     = INSTR_W;
`endif

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

`ifdef IMEM_PARITY_EN
    function automatic logic even_par(input logic [INSTR_W-1:0] d);
        return ^d;
    endfunction

    function automatic logic par_bad(input logic [MEM_W-1:0] w);
        return ^w;
    endfunction
`endif

    logic [MEM_W-1:0]   mem_r [0:MEM_WORDS-1];
    logic [1:0]         state_r, state_s;
    logic [ADDR_W-1:0]  wptr_r, wptr_s;
    logic [BANK_W-1:0]  lbank_r, lbank_s;
    logic               err_r, err_s;
    logic               wr_en_s;
    logic               ready_r, busy_r, done_r;
    logic [INSTR_W-1:0] instr_r;
    logic               valid_r;
    logic [MEM_W-1:0]   wdata_s;
    logic [MEM_W-1:0]   rd_s;

    // Load FSM next-state and write-strobe decode.
    always_comb begin
        state_s = state_r;
        wptr_s  = wptr_r;
        lbank_s = lbank_r;
        err_s   = err_r;
        wr_en_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.load_start) begin
                    state_s = ST_LOAD;
                    wptr_s  = {ADDR_W{1'b0}};
                    lbank_s = bus.load_bank;
                    err_s   = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (bus.load_valid) begin
                    wr_en_s = 1'b1;
                    if (bus.load_last) begin
                        state_s = ST_DONE;
                    end else if (wptr_r == LAST_ADDR) begin
                        // Image overran the bank: stop rather than wrap onto word 0.
                        err_s   = 1'b1;
                        state_s = ST_DONE;
                    end else begin
                        wptr_s = wptr_r + ADDR_ONE;
                    end
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Load FSM state and its registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            wptr_r  <= {ADDR_W{1'b0}};
            lbank_r <= {BANK_W{1'b0}};
            err_r   <= 1'b0;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            wptr_r  <= wptr_s;
            lbank_r <= lbank_s;
            err_r   <= err_s;
            ready_r <= (state_s == ST_LOAD);
            busy_r  <= (state_s == ST_LOAD);
            done_r  <= (state_s == ST_DONE);
        end
    end

`ifdef IMEM_PARITY_EN
    assign wdata_s = {even_par(bus.load_data), bus.load_data};
`else
    assign wdata_s = bus.load_data;
`endif

    // Program storage; deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en_s && !reset) begin
            mem_r[{lbank_r, wptr_r}] <= wdata_s;
        end
    end

    assign rd_s = mem_r[{bus.bank_sel, bus.pc}];

    // Fetch register: reset, load-busy and flush all force the halt word.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_r <= NOP_WORD;
            valid_r <= 1'b0;
        end else if (busy_r) begin
            instr_r <= NOP_WORD;
            valid_r <= 1'b0;
        end else if (bus.flush) begin
            instr_r <= NOP_WORD;
            valid_r <= 1'b0;
        end else if (bus.fetch_en) begin
`ifdef IMEM_PARITY_EN
            if (par_bad(rd_s)) begin
                instr_r <= NOP_WORD;
                valid_r <= 1'b0;
            end else begin
                instr_r <= rd_s[INSTR_W-1:0];
                valid_r <= 1'b1;
            end
`else
            instr_r <= rd_s;
            valid_r <= 1'b1;
`endif
        end else begin
            instr_r <= instr_r;
            valid_r <= valid_r;
        end
    end

`ifdef IMEM_PARITY_EN
    logic par_r;

    // Sticky parity error, raised only by a real (non-suppressed) fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            par_r <= 1'b0;
        end else if (!busy_r && !bus.flush && bus.fetch_en && par_bad(rd_s)) begin
            par_r <= 1'b1;
        end else begin
            par_r <= par_r;
        end
    end

    assign parity_err = par_r;
`endif

    assign bus.instr_out   = instr_r;
    assign bus.instr_valid = valid_r;
    assign bus.load_ready  = ready_r;
    assign bus.busy        = busy_r;
    assign bus.load_done   = done_r;
    assign bus.load_err    = err_r;
endmodule

// File: tb/tb_prog_imem.sv
// Randomized bench for prog_imem with a behavioural memory/load-session model
// and a handful of literal expectations taken straight from the test plan.
module tb_prog_imem;
    localparam int DEPTH = 256;
    localparam logic [8:0] NOP = 9'b110111000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    prog_imem_if #(.INSTR_W(9), .ADDR_W(8), .BANK_W(2)) bus ();
`ifdef IMEM_PARITY_EN
    logic parity_err;
`endif

    prog_imem #(.INSTR_W(9), .ADDR_W(8), .NUM_BANKS(4), .NOP_WORD(9'b110111000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef IMEM_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    // Model: memory image with "ever written" and "corrupted" flags, plus load session.
    logic [8:0] m_mem   [DEPTH*4];
    bit         m_known [DEPTH*4];
    bit         m_bad   [DEPTH*4];
    logic [8:0] e_instr;
    bit e_valid, e_known, e_busy, e_done, e_err, e_par;
    int m_bank, m_ptr;
    bit check_on = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        int  idx;
        bit  nd;
        if (reset) begin
            e_instr = NOP; e_valid = 1'b0; e_known = 1'b1;
            e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0; e_par = 1'b0;
        end else begin
            if (e_busy || bus.flush) begin
                e_instr = NOP; e_valid = 1'b0; e_known = 1'b1;
            end else if (bus.fetch_en) begin
                idx = int'(bus.bank_sel) * DEPTH + int'(bus.pc);
                if (m_bad[idx]) begin
                    e_instr = NOP; e_valid = 1'b0; e_known = 1'b1; e_par = 1'b1;
                end else begin
                    e_instr = m_mem[idx]; e_valid = 1'b1; e_known = m_known[idx];
                end
            end
            nd = 1'b0;
            if (e_busy) begin
                if (bus.load_valid) begin
                    idx = m_bank * DEPTH + m_ptr;
                    m_mem[idx] = bus.load_data; m_known[idx] = 1'b1; m_bad[idx] = 1'b0;
                    if (bus.load_last) begin
                        e_busy = 1'b0; nd = 1'b1;
                    end else if (m_ptr == DEPTH - 1) begin
                        e_err = 1'b1; e_busy = 1'b0; nd = 1'b1;
                    end else begin
                        m_ptr++;
                    end
                end
            end else if (!e_done && bus.load_start) begin
                e_busy = 1'b1; m_bank = int'(bus.load_bank); m_ptr = 0; e_err = 1'b0;
            end
            e_done = nd;
        end
    end

    always @(negedge clk) begin
        if (check_on) begin
            chk("instr_valid", 9'(bus.instr_valid), 9'(e_valid));
            if (!e_valid || e_known) chk("instr_out", bus.instr_out, e_instr);
            chk("load_ready", 9'(bus.load_ready), 9'(e_busy));
            chk("busy", 9'(bus.busy), 9'(e_busy));
            chk("load_done", 9'(bus.load_done), 9'(e_done));
            chk("load_err", 9'(bus.load_err), 9'(e_err));
`ifdef IMEM_PARITY_EN
            chk("parity_err", 9'(parity_err), 9'(e_par));
`endif
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic load_img(input int bank, input int n, input int base, input bit rnd, input bit with_last);
        bus.load_start = 1'b1;
        bus.load_bank  = 2'(bank);
        cyc();
        bus.load_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = rnd ? 9'($urandom) : 9'(base + i);
            bus.load_last  = with_last && (i == n - 1);
            cyc();
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH * 4; i++) begin
            m_known[i] = 1'b0; m_bad[i] = 1'b0; m_mem[i] = 9'h000;
        end
        reset = 1'b1;
        bus.pc = 8'h00; bus.bank_sel = 2'd0; bus.fetch_en = 1'b1; bus.flush = 1'b0;
        bus.load_start = 1'b0; bus.load_bank = 2'd0; bus.load_data = 9'h000;
        bus.load_valid = 1'b0; bus.load_last = 1'b0;
        cyc();
        check_on = 1'b1;
        cyc();
        chk("rst_instr", bus.instr_out, 9'h1B8);
        chk("rst_valid", 9'(bus.instr_valid), 9'h000);

        reset = 1'b0; bus.fetch_en = 1'b0;
        cyc();
        chk("post_rst_hold_valid", 9'(bus.instr_valid), 9'h000);
`ifdef IMEM_PARITY_EN
        for (int b = 0; b < 4; b++) begin
            load_img(b, DEPTH, 0, 1'b1, 1'b1);
            cyc();
        end
`endif
        bus.fetch_en = 1'b1;
        cyc();
        chk("first_fetch_valid", 9'(bus.instr_valid), 9'h001);
        bus.fetch_en = 1'b0;

        // 18-word image into bank 1, then read it back in order.
        load_img(1, 18, 9'h0C8, 1'b0, 1'b1);
        chk("img18_done", 9'(bus.load_done), 9'h001);
        chk("img18_err", 9'(bus.load_err), 9'h000);
        cyc();
        chk("img18_done_pulse", 9'(bus.load_done), 9'h000);
        bus.bank_sel = 2'd1; bus.fetch_en = 1'b1;
        for (int i = 0; i < 18; i++) begin
            bus.pc = 8'(i);
            cyc();
            chk("img18_word", bus.instr_out, 9'(9'h0C8 + i));
        end

        // Stall holds word 5 while pc moves; flush gives a bubble.
        bus.pc = 8'd5;
        cyc();
        chk("stall_pre", bus.instr_out, 9'h0CD);
        bus.fetch_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.pc = 8'(6 + k);
            cyc();
            chk("stall_hold", bus.instr_out, 9'h0CD);
        end
        bus.fetch_en = 1'b1; bus.flush = 1'b1;
        cyc();
        chk("flush_instr", bus.instr_out, 9'h1B8);
        chk("flush_valid", 9'(bus.instr_valid), 9'h000);
        bus.flush = 1'b0; bus.fetch_en = 1'b0;

        // Overflow: a full bank with no load_last.
        load_img(2, DEPTH, 0, 1'b1, 1'b0);
        chk("ovf_err", 9'(bus.load_err), 9'h001);
        chk("ovf_done", 9'(bus.load_done), 9'h001);
        chk("ovf_busy", 9'(bus.busy), 9'h000);
        cyc();
        chk("ovf_err_sticky", 9'(bus.load_err), 9'h001);
        bus.load_start = 1'b1; bus.load_bank = 2'd2;
        cyc();
        bus.load_start = 1'b0;
        chk("restart_clears_err", 9'(bus.load_err), 9'h000);
        bus.load_valid = 1'b1; bus.load_data = 9'h055; bus.load_last = 1'b1;
        cyc();
        bus.load_valid = 1'b0; bus.load_last = 1'b0;
        cyc();

        // Reset after 4 words of a reload of bank 1.
        load_img(1, 4, 9'h100, 1'b0, 1'b0);
        reset = 1'b1;
        cyc();
        chk("midrst_busy", 9'(bus.busy), 9'h000);
        chk("midrst_done", 9'(bus.load_done), 9'h000);
        reset = 1'b0; bus.bank_sel = 2'd1; bus.fetch_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.pc = 8'(i);
            cyc();
            chk("midrst_word", bus.instr_out, (i < 4) ? 9'(9'h100 + i) : 9'(9'h0C8 + i));
        end

`ifdef IMEM_PARITY_EN
        bus.fetch_en = 1'b0;
        dut.mem_r[263] = dut.mem_r[263] ^ 10'h001;
        m_bad[263] = 1'b1;
        bus.pc = 8'd7; bus.fetch_en = 1'b1;
        cyc();
        chk("par_flag", 9'(parity_err), 9'h001);
        chk("par_instr", bus.instr_out, 9'h1B8);
        chk("par_valid", 9'(bus.instr_valid), 9'h000);
        bus.pc = 8'd8;
        cyc();
        chk("par_sticky", 9'(parity_err), 9'h001);
`endif

        // Random traffic: fetch/stall/flush, bank switches, loads, occasional reset.
        for (int n = 0; n < 3000; n++) begin
            reset          = ($urandom_range(0, 249) == 0);
            bus.fetch_en   = ($urandom_range(0, 3) != 0);
            bus.flush      = ($urandom_range(0, 9) == 0);
            bus.pc         = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31));
            bus.bank_sel   = 2'($urandom);
            bus.load_start = ($urandom_range(0, 19) == 0);
            bus.load_bank  = 2'($urandom);
            bus.load_valid = ($urandom_range(0, 2) != 0);
            bus.load_data  = 9'($urandom);
            bus.load_last  = ($urandom_range(0, 39) == 0);
            cyc();
        end
        reset = 1'b0; bus.load_start = 1'b0; bus.load_valid = 1'b0;
        cyc();
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/prog_imem.md
# prog_imem

Parametrised, loadable instruction memory for the 9-bit pipelined CPU; replaces the fixed per-program ROMs. Holds `NUM_BANKS` program images of `DEPTH` words each. Fetch is registered and supports stall and flush from the pipeline. A streaming load port writes any bank at run time, so test programs are swapped without resynthesis.

## Interface
- `INSTR_W`, 9: instruction width.
- `ADDR_W`, 8: PC width; `DEPTH` = 2**ADDR_W.
- `NUM_BANKS`, 4: program images; `BANK_W` = $clog2(NUM_BANKS), minimum 1.
- `NOP_WORD`, 9'b110111000: word driven when no valid instruction is available (halt encoding).

- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `pc`  in  ADDR_W  fetch address.
- `bank_sel`  in  BANK_W  active program bank for fetch.
- `fetch_en`  in  1  1 = advance fetch; 0 = stall (hold output).
- `flush`  in  1  discard the in-flight fetch.
- `instr_out`  out  INSTR_W  fetched instruction (registered).
- `instr_valid`  out  1  `instr_out` is a real fetched word.
- `load_start`  in  1  begin loading bank `load_bank` at address 0.
- `load_bank`  in  BANK_W  target bank, sampled on `load_start`.
- `load_data`  in  INSTR_W  word to write.
- `load_valid`  in  1  `load_data` present.
- `load_last`  in  1  qualifies the final word of the image.
- `load_ready`  out  1  load port accepts a word this cycle.
- `busy`  out  1  load in progress; fetch suppressed.
- `load_done`  out  1  one-cycle pulse at load completion.
- `load_err`  out  1  sticky overflow flag; cleared by `load_start` or `reset`.
- `parity_err`  out  1  sticky; present only with `IMEM_PARITY_EN`.

## Operation
- Storage: NUM_BANKS×DEPTH words. Not cleared by reset; contents are undefined until loaded.
- Load FSM states:
  - IDLE: `load_ready`=0. `load_start` latches the bank, clears the write pointer and `load_err`, and moves to LOAD.
  - LOAD: `load_ready`=1, `busy`=1. On `load_valid`&`load_ready`, write `mem[bank][wptr]` and increment `wptr`.
    - Accepted word with `load_last`=1 → DONE.
    - Accepted word at `wptr`=DEPTH-1 with `load_last`=0 → set `load_err`, go to DONE. The pointer never wraps.
  - DONE: `load_done`=1 for one cycle, `busy`=0 that cycle, then return to IDLE.
- `load_start` in LOAD or DONE is ignored.
- Fetch rules (evaluated in priority order):
  - `reset`: `instr_out`=NOP_WORD, `instr_valid`=0.
  - `busy`: `instr_out`=NOP_WORD, `instr_valid`=0, regardless of `fetch_en`.
  - `flush`: `instr_out`=NOP_WORD, `instr_valid`=0 next cycle. Flush wins over `fetch_en`.
  - `fetch_en`=1: `instr_out`←`mem[bank_sel][pc]`, `instr_valid`←1.
  - `fetch_en`=0: hold `instr_out` and `instr_valid`.
- `bank_sel` changes take effect on the next fetch; no word from the old bank is emitted after that.

## Timing
- Fetch latency: 1 cycle from `pc` sampled to `instr_out`.
- Stall has zero added latency. Flush bubble: 1 cycle.
- Load throughput: 1 word per cycle. A word written in cycle N is fetchable from cycle N+2 (after DONE).
- Reset mid-load: FSM returns to IDLE, `busy`=0, no `load_done` pulse. Words already written stay in memory; the rest of the bank is stale.
- Reset values: `instr_out`=NOP_WORD, `instr_valid`=0, `load_ready`=0, `busy`=0, `load_done`=0, `load_err`=0, `parity_err`=0.

## Configuration
- `IMEM_PARITY_EN` defined:
  - Each word stores an extra even-parity bit, computed on load.
  - Each fetch checks parity. On mismatch, set sticky `parity_err`, drive `instr_out`=NOP_WORD and `instr_valid`=0 for that fetch.
  - `parity_err` clears only on `reset`.
- Undefined: no parity storage. `parity_err` port is absent. Fetch returns raw data.

## Test plan
- Reset, then idle with `fetch_en`=1 → `instr_out`=9'b110111000, `instr_valid`=0 until the first fetch after reset is released.
- Load bank 1 with 18 words 9'h0C8..9'h0D9, `load_last` on the 18th → `load_done` pulses 1 cycle after the 18th word, `load_err`=0. Then fetch `pc`=0..17 with `bank_sel`=1 → words returned in order with 1-cycle latency.
- Fetch `pc`=5, drop `fetch_en` for 3 cycles while `pc` changes → `instr_out` holds word 5. Assert `flush` with `fetch_en`=1 → next cycle NOP_WORD, `instr_valid`=0.
- Stream 256 words into bank 2 without `load_last` → `load_err`=1 after the 256th write, `load_done` pulses, `busy` falls. Next `load_start` clears `load_err`.
- Assert `reset` after 4 of 10 load words → `busy`=0 next cycle, no `load_done`. Words 0..3 are readable; the rest are unchanged.
- With `IMEM_PARITY_EN`: force a bit flip in a stored word, then fetch it → `parity_err`=1 sticky, `instr_out`=NOP_WORD, `instr_valid`=0.
